// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern engine (rotate/ping-pong/flash); LED_SEQUENCER_DIMMER_EN adds PWM dimming
module led_sequencer #(
  parameter int NB_LEDS    = 4,
  parameter int NB_COUNTER = 16,
  parameter int NB_RATE    = 3
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_RATE-1:0] i_rate,
  input  logic [1:0]         i_mode,
  input  logic               i_color,
`ifdef LED_SEQUENCER_DIMMER_EN
  input  logic [3:0]         i_duty,
`endif
  output logic [NB_LEDS-1:0] o_led,
  output logic [NB_LEDS-1:0] o_led_b,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic               o_tick
);
  typedef enum logic {LEFT, RIGHT} dir_t;
  localparam logic [NB_COUNTER-1:0] ALL_ONES = '1;
  localparam logic [NB_LEDS-1:0] LSB = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] MSB = {1'b1, {(NB_LEDS-1){1'b0}}};
  logic [NB_COUNTER-1:0] count, limit;
  logic [NB_LEDS-1:0] pattern, seed, rot_l, rot_r, pong, stepped, next_pattern, gate;
  logic [1:0] mode_q;
  dir_t dir, dir_next;
  always_comb begin
    limit = ALL_ONES >> i_rate;
    seed = i_mode == 2'b01 ? MSB : i_mode == 2'b11 ? '0 : LSB;
    rot_l = {pattern[NB_LEDS-2:0], pattern[NB_LEDS-1]};
    rot_r = {pattern[0], pattern[NB_LEDS-1:1]};
    // ping-pong turns around when the lit bit reaches the end it is heading for
    dir_next = (dir == LEFT ? pattern[NB_LEDS-1] : pattern[0]) ? (dir == LEFT ? RIGHT : LEFT) : dir;
    pong = dir_next == LEFT ? pattern << 1 : pattern >> 1;
    stepped = mode_q == 2'b00 ? rot_l : mode_q == 2'b01 ? rot_r : mode_q == 2'b10 ? pong : ~pattern;
    next_pattern = (mode_q != 2'b11 && stepped == '0) ? seed : stepped;
  end
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
      pattern <= LSB;
      dir <= LEFT;
      mode_q <= 2'b00;
      o_tick <= 1'b0;
    end else if (i_mode != mode_q) begin
      mode_q <= i_mode;
      count <= '0;
      o_tick <= 1'b0;
      pattern <= seed;
      dir <= LEFT;
    end else if (!i_enable) begin
      o_tick <= 1'b0;
    end else if (count >= limit) begin
      count <= '0;
      o_tick <= 1'b1;
      pattern <= next_pattern;
      if (mode_q == 2'b10) dir <= dir_next;
    end else begin
      count <= count + NB_COUNTER'(1);
      o_tick <= 1'b0;
    end
  end
`ifdef LED_SEQUENCER_DIMMER_EN
  logic [3:0] pwm_cnt;
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) pwm_cnt <= 4'd0;
    else pwm_cnt <= pwm_cnt + 4'd1;
  end
  assign gate = {NB_LEDS{pwm_cnt < i_duty}};
`else
  assign gate = '1;
`endif
  assign o_led = pattern & gate;
  assign o_led_b = i_color ? '0 : o_led;
  assign o_led_g = i_color ? o_led : '0;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed checks of step timing, pattern modes, freeze, colour routing and async reset
module tb_led_sequencer;
  logic clock = 1'b0, i_reset = 1'b0, i_enable = 1'b1, i_color = 1'b0;
  logic [1:0] i_rate = 2'd0, i_mode = 2'd0;
  logic [3:0] o_led, o_led_b, o_led_g;
  logic o_tick;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

`ifdef LED_SEQUENCER_DIMMER_EN
  logic [3:0] i_duty = 4'd15, pwm;
  always @(posedge clock or negedge i_reset) pwm <= !i_reset ? 4'd0 : pwm + 4'd1;
  function automatic logic [3:0] lit(input logic [3:0] x);
    return x & {4{pwm < i_duty}};
  endfunction
`else
  function automatic logic [3:0] lit(input logic [3:0] x);
    return x;
  endfunction
`endif

  led_sequencer #(.NB_LEDS(4), .NB_COUNTER(4), .NB_RATE(2)) dut (
    .clock(clock),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .i_rate(i_rate),
    .i_mode(i_mode),
    .i_color(i_color),
`ifdef LED_SEQUENCER_DIMMER_EN
    .i_duty(i_duty),
`endif
    .o_led(o_led),
    .o_led_b(o_led_b),
    .o_led_g(o_led_g),
    .o_tick(o_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // waits one full step period and checks the tick lands exactly on its last edge
  task automatic expect_step(input int period, input logic [3:0] led);
    repeat (period - 1) @(negedge clock);
    check("no_tick_before_step", {31'd0, o_tick}, 32'd0);
    @(negedge clock);
    check("tick", {31'd0, o_tick}, 32'd1);
    check("led_step", {28'd0, o_led}, {28'd0, lit(led)});
  endtask

  initial begin
    int n;
    @(negedge clock);
    check("reset_led", {28'd0, o_led}, {28'd0, lit(4'b0001)});
    check("reset_tick", {31'd0, o_tick}, 32'd0);
    i_reset = 1'b1;
    // rotate left at the slowest rate
    expect_step(16, 4'b0010);
    expect_step(16, 4'b0100);
    expect_step(16, 4'b1000);
    expect_step(16, 4'b0001);
    // ping-pong, limit 3
    i_mode = 2'b10;
    i_rate = 2'd2;
    @(negedge clock);
    check("pong_seed", {28'd0, o_led}, {28'd0, lit(4'b0001)});
    check("pong_seed_tick", {31'd0, o_tick}, 32'd0);
    expect_step(4, 4'b0010);
    expect_step(4, 4'b0100);
    expect_step(4, 4'b1000);
    expect_step(4, 4'b0100);
    expect_step(4, 4'b0010);
    expect_step(4, 4'b0001);
    expect_step(4, 4'b0010);
    // rate increase mid-count
    i_mode = 2'b00;
    i_rate = 2'd0;
    @(negedge clock);
    check("rot_seed", {28'd0, o_led}, {28'd0, lit(4'b0001)});
    repeat (10) @(negedge clock);
    check("count10_no_tick", {31'd0, o_tick}, 32'd0);
    check("count10_led", {28'd0, o_led}, {28'd0, lit(4'b0001)});
    i_rate = 2'd3;
    @(negedge clock);
    check("rate_up_tick", {31'd0, o_tick}, 32'd1);
    check("rate_up_led", {28'd0, o_led}, {28'd0, lit(4'b0010)});
    expect_step(2, 4'b0100);
    // mode change mid-count beats the pending step
    @(negedge clock);
    i_mode = 2'b01;
    i_rate = 2'd2;
    @(negedge clock);
    check("rotr_seed", {28'd0, o_led}, {28'd0, lit(4'b1000)});
    check("rotr_seed_tick", {31'd0, o_tick}, 32'd0);
    expect_step(4, 4'b0100);
    expect_step(4, 4'b0010);
    // flash, then freeze while moving the colour
    i_mode = 2'b11;
    @(negedge clock);
    check("flash_seed", {28'd0, o_led}, {28'd0, lit(4'b0000)});
    expect_step(4, 4'b1111);
    repeat (2) @(negedge clock);
    i_enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) i_color = 1'b1;
      @(negedge clock);
      check("frozen_led", {28'd0, o_led}, {28'd0, lit(4'b1111)});
      check("frozen_tick", {31'd0, o_tick}, 32'd0);
      check("frozen_b", {28'd0, o_led_b}, {28'd0, i_color ? 4'b0000 : lit(4'b1111)});
      check("frozen_g", {28'd0, o_led_g}, {28'd0, i_color ? lit(4'b1111) : 4'b0000});
    end
    i_enable = 1'b1;
    expect_step(2, 4'b0000);
    // asynchronous reset between edges
    #2 i_reset = 1'b0;
    #1;
    check("async_led", {28'd0, o_led}, {28'd0, lit(4'b0001)});
    check("async_tick", {31'd0, o_tick}, 32'd0);
    check("async_g", {28'd0, o_led_g}, {28'd0, lit(4'b0001)});
    i_mode = 2'b00;
    i_rate = 2'd0;
    @(negedge clock);
    i_reset = 1'b1;
    expect_step(16, 4'b0010);
`ifdef LED_SEQUENCER_DIMMER_EN
    i_duty = 4'd4;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (o_led != 4'd0) n++;
    end
    check("duty4_lit", n, 32'd4);
    i_duty = 4'd0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (o_led != 4'd0) n++;
    end
    check("duty0_lit", n, 32'd0);
`else
    n = 0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
